// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared constants and types for the neuron layer sequencer:
//                datapath lane width and fan-in, weight ROM word layout,
//                sequencer FSM encoding and the in-flight neuron tag.
//  Revision    : 1.0  initial release
// ============================================================================
package nn_pkg;

  // Datapath lane width (17-bit signed fixed point) and neuron fan-in.
  localparam int W_BITS = 17;
  localparam int N_IN   = 7;

  // Weight ROM word layout: {w[N_IN-1..0], bias}.
  localparam int BIAS_LSB = 0;
  localparam int W_LSB    = 17;
  localparam int ROM_W    = W_BITS * (N_IN + 1);

  // The tag index field is sized for the widest supported ROM address, so
  // one struct serves every AW <= TAG_IDX_W.
  localparam int TAG_IDX_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] index;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/neuron_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_layer_sequencer_if
//  Description : Bus bundle between the sequencer and its weight ROM plus
//                the pipelined neuron datapath.
//                  w_rd_en  : ROM read strobe            (master -> slave)
//                  w_addr   : ROM address = neuron index (master -> slave)
//                  w_rdata  : ROM word, one cycle after w_rd_en (slave -> master)
//                  neu_x    : neuron x vector            (master -> slave)
//                  neu_w    : neuron weight vector       (master -> slave)
//                  neu_bias : neuron bias                (master -> slave)
//                  neu_y    : neuron activation          (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface neuron_layer_sequencer_if #(
  parameter int AW = 3
);
  import nn_pkg::*;

  logic                     w_rd_en;
  logic [AW-1:0]            w_addr;
  logic [ROM_W-1:0]         w_rdata;
  logic [W_BITS*N_IN-1:0]   neu_x;
  logic [W_BITS*N_IN-1:0]   neu_w;
  logic [W_BITS-1:0]        neu_bias;
  logic [W_BITS-1:0]        neu_y;

  modport master (
    output w_rd_en, w_addr, neu_x, neu_w, neu_bias,
    input  w_rdata, neu_y
  );

  modport slave (
    input  w_rd_en, w_addr, neu_x, neu_w, neu_bias,
    output w_rdata, neu_y
  );

endinterface
`default_nettype wire

// File: rtl/nn_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : nn_tag_pipe
//  Description : Delay line of DEPTH stages carrying {valid, index} tags in
//                lock-step with neurons travelling through the datapath.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                tag_in    - tag entering stage 0
//                tag_out   - tag leaving the last stage
//                empty     - no tag remains in flight once the tag currently
//                            at the output has been consumed
//  Revision    : 1.0  initial release
// ============================================================================
module nn_tag_pipe
  import nn_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire tag_t tag_in,
  output tag_t      tag_out,
  output logic      empty
);

  tag_t stage_q [DEPTH];
  tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

  // The output stage is excluded: it retires this cycle, which lets the
  // sequencer leave DRAIN in the same cycle the last result is captured.
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (stage_q[i].valid) begin
        empty = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/neuron_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_layer_sequencer
//  Description : Time-multiplexes one pipelined 7-input neuron across all
//                neurons of a layer. Issues one ROM read per neuron, tracks
//                in-flight neurons with a tag pipe and gathers each
//                activation into a packed layer output vector.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                start        - begin a run (sampled only in IDLE)
//                n_neurons    - neurons this run, clamped to NMAX
//                x_in         - layer input vector, latched on start
//                busy, done   - run in progress / one-cycle end pulse
//                bus          - ROM and neuron datapath bundle (master side)
//                y_out        - packed results, lane k = [17k+16:17k]
//                cycles_last  - cycles from start to done, inclusive
//  Options     : SEQ_PERF_CNT_EN - when defined, cycles_last reports the
//                length of the last run; otherwise it is tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module neuron_layer_sequencer
  import nn_pkg::*;
#(
  parameter int NMAX     = 7,
  parameter int PIPE_LAT = 7,
  parameter int AW       = 3
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       start,
  input  wire logic [3:0]                 n_neurons,
  input  wire logic [W_BITS*N_IN-1:0]     x_in,
  output logic                            busy,
  output logic                            done,
  neuron_layer_sequencer_if.master        bus,
  output logic [W_BITS*NMAX-1:0]          y_out,
  output logic [15:0]                     cycles_last
);

  seq_state_e                 state_q, state_d;
  logic [AW-1:0]              idx_q, idx_d;
  logic [3:0]                 n_eff_q, n_eff_d;
  logic [W_BITS*N_IN-1:0]     x_q, x_d;
  logic [W_BITS*NMAX-1:0]     y_q, y_d;

  logic [3:0]                 n_clamp;
  logic                       last_issue;
  tag_t                       tag_in;
  tag_t                       tag_out;
  logic                       pipe_empty;

  assign n_clamp    = (32'(n_neurons) > NMAX) ? 4'(NMAX) : n_neurons;
  assign last_issue = ((32'(idx_q) + 1) == 32'(n_eff_q));

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_eff_d = n_eff_q;
    x_d     = x_q;
    tag_in  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x_in;
          n_eff_d = n_clamp;
          idx_d   = '0;
          state_d = (n_clamp == 4'd0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        tag_in.valid = 1'b1;
        tag_in.index = TAG_IDX_W'(idx_q);
        if (last_issue) begin
          idx_d   = '0;
          state_d = S_DRAIN;
        end else begin
          idx_d   = idx_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (pipe_empty) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_eff_q <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_eff_q <= n_eff_d;
      x_q     <= x_d;
    end
  end

  assign busy         = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done         = (state_q == S_FIN);
  assign bus.w_rd_en  = (state_q == S_ISSUE);
  assign bus.w_addr   = idx_q;
  assign bus.neu_x    = x_q;
  assign bus.neu_w    = bus.w_rdata[W_LSB +: W_BITS*N_IN];
  assign bus.neu_bias = bus.w_rdata[BIAS_LSB +: W_BITS];

  // --------------------------------------------------------------------------
  // In-flight tracking: one extra stage covers the ROM read latency.
  // --------------------------------------------------------------------------
  nn_tag_pipe #(
    .DEPTH (1 + PIPE_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .empty   (pipe_empty)
  );

  // --------------------------------------------------------------------------
  // Result collection: only the lane named by a valid retiring tag changes.
  // --------------------------------------------------------------------------
  always_comb begin
    y_d = y_q;
    if (tag_out.valid) begin
      for (int k = 0; k < NMAX; k++) begin
        if (tag_out.index == TAG_IDX_W'(k)) begin
          y_d[W_BITS*k +: W_BITS] = bus.neu_y;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y_out = y_q;

  // --------------------------------------------------------------------------
  // Run-length counter
  // --------------------------------------------------------------------------
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cycles_last_q, cycles_last_d;
  logic [16:0] run_len;

  // The counter only covers busy cycles; the start cycle and the done cycle
  // are added when the result is loaded.
  assign run_len = {1'b0, cnt_q} + 17'd2;

  always_comb begin
    cnt_d         = cnt_q;
    cycles_last_d = cycles_last_q;
    if ((state_q == S_IDLE) && start) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (state_q == S_FIN) begin
      cycles_last_d = run_len[16] ? 16'hFFFF : run_len[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      cycles_last_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      cycles_last_q <= cycles_last_d;
    end
  end

  assign cycles_last = cycles_last_q;
`else
  assign cycles_last = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_neuron_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_layer_sequencer
//  Description : Self-checking bench for neuron_layer_sequencer. Provides a
//                synchronous weight ROM (bias of word k = rom_base + k) and
//                a neuron stub whose output is its bias delayed PIPE_LAT
//                clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_neuron_layer_sequencer;
  import nn_pkg::*;

  localparam int NMAX     = 7;
  localparam int PIPE_LAT = 7;
  localparam int AW       = 3;

`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic [3:0]             n_neurons;
  logic [W_BITS*N_IN-1:0] x_in;
  logic                   busy;
  logic                   done;
  logic [W_BITS*NMAX-1:0] y_out;
  logic [15:0]            cycles_last;
  logic [16:0]            rom_base;
  logic [16:0]            stub [PIPE_LAT];

  int checks   = 0;
  int failures = 0;

  neuron_layer_sequencer_if #(.AW(AW)) bus ();

  neuron_layer_sequencer #(
    .NMAX     (NMAX),
    .PIPE_LAT (PIPE_LAT),
    .AW       (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .n_neurons   (n_neurons),
    .x_in        (x_in),
    .busy        (busy),
    .done        (done),
    .bus         (bus),
    .y_out       (y_out),
    .cycles_last (cycles_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight ROM: registered read.
  always_ff @(posedge clk) begin
    if (bus.w_rd_en) begin
      bus.w_rdata <= {{N_IN{17'(bus.w_addr)}}, rom_base + 17'(bus.w_addr)};
    end
  end

  // Neuron stub: y = bias delayed PIPE_LAT clocks.
  always_ff @(posedge clk) begin
    stub[0] <= bus.neu_bias;
    for (int i = 1; i < PIPE_LAT; i++) begin
      stub[i] <= stub[i-1];
    end
  end
  assign bus.neu_y = stub[PIPE_LAT-1];

  typedef struct {
    int                     n;
    logic [16:0]            base;
    int                     again_t;
    bit                     at_fin;
    int                     exp_done_t;
    int                     exp_rd;
    logic [W_BITS*NMAX-1:0] exp_y;
    logic [15:0]            exp_cl;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered at #1 after a rising edge with the DUT in IDLE; that cycle is T0.
  task automatic run_vec(input vec_t v, input int id);
    int          done_t   = -1;
    int          done_cnt = 0;
    int          rd_cnt   = 0;
    bit          busy_ok  = 1'b1;
    bit          addr_ok  = 1'b1;
    logic [16:0] xl;
    logic [W_BITS*N_IN-1:0] xpat;
    xl        = 17'h0A5A5 + 17'(id);
    xpat      = {N_IN{xl}};
    rom_base  = v.base;
    x_in      = xpat;
    n_neurons = 4'(v.n);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x_in  = ~xpat;
    for (int t = 1; t <= v.exp_done_t + 3; t++) begin
      if (done) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
      if (busy !== (t < v.exp_done_t)) busy_ok = 1'b0;
      if (bus.w_rd_en) begin
        rd_cnt++;
        if (bus.w_addr !== AW'(t - 1)) addr_ok = 1'b0;
      end
      if ((t == v.again_t) || (v.at_fin && (t == v.exp_done_t))) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check($sformatf("v%0d done_cycle", id), 128'(done_t), 128'(v.exp_done_t));
    check($sformatf("v%0d done_count", id), 128'(done_cnt), 128'd1);
    check($sformatf("v%0d rd_count", id), 128'(rd_cnt), 128'(v.exp_rd));
    check($sformatf("v%0d addr_seq", id), 128'(addr_ok), 128'd1);
    check($sformatf("v%0d busy_window", id), 128'(busy_ok), 128'd1);
    check($sformatf("v%0d y_out", id), 128'(y_out), 128'(v.exp_y));
    check($sformatf("v%0d cycles_last", id), 128'(cycles_last), 128'(v.exp_cl));
    check($sformatf("v%0d neu_x_held", id), 128'(bus.neu_x), 128'(xpat));
  endtask

  localparam logic [W_BITS*NMAX-1:0] Y_FULL1 =
    {17'h106, 17'h105, 17'h104, 17'h103, 17'h102, 17'h101, 17'h100};
  localparam logic [W_BITS*NMAX-1:0] Y_PART2 =
    {17'h106, 17'h105, 17'h104, 17'h103, 17'h202, 17'h201, 17'h200};
  localparam logic [W_BITS*NMAX-1:0] Y_FULL3 =
    {17'h306, 17'h305, 17'h304, 17'h303, 17'h302, 17'h301, 17'h300};
  localparam logic [W_BITS*NMAX-1:0] Y_AFTER_RST =
    {17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h041, 17'h040};

  vec_t vecs [5];
  vec_t post;

  initial begin
    int n_done;
    int n_rd;

    // n, base, again_t, at_fin, exp_done_t, exp_rd, exp_y, exp_cl
    vecs[0] = '{7,  17'h100, 0, 1'b0, 16, 7, Y_FULL1, PERF ? 16'd17 : 16'd0};
    vecs[1] = '{3,  17'h200, 0, 1'b0, 12, 3, Y_PART2, PERF ? 16'd13 : 16'd0};
    vecs[2] = '{0,  17'h3FF, 0, 1'b0, 1,  0, Y_PART2, PERF ? 16'd2  : 16'd0};
    vecs[3] = '{12, 17'h100, 0, 1'b0, 16, 7, Y_FULL1, PERF ? 16'd17 : 16'd0};
    vecs[4] = '{7,  17'h300, 5, 1'b1, 16, 7, Y_FULL3, PERF ? 16'd17 : 16'd0};
    post    = '{2,  17'h040, 0, 1'b0, 11, 2, Y_AFTER_RST, PERF ? 16'd12 : 16'd0};

    rst       = 1'b1;
    start     = 1'b0;
    n_neurons = '0;
    x_in      = '0;
    rom_base  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst busy",        128'(busy),        128'd0);
    check("rst done",        128'(done),        128'd0);
    check("rst w_rd_en",     128'(bus.w_rd_en), 128'd0);
    check("rst w_addr",      128'(bus.w_addr),  128'd0);
    check("rst neu_x",       128'(bus.neu_x),   128'd0);
    check("rst y_out",       128'(y_out),       128'd0);
    check("rst cycles_last", 128'(cycles_last), 128'd0);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset in T6 of a 7-neuron run.
    rom_base  = 17'h155;
    x_in      = {N_IN{17'h01234}};
    n_neurons = 4'd7;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst busy",        128'(busy),        128'd0);
    check("midrst done",        128'(done),        128'd0);
    check("midrst w_rd_en",     128'(bus.w_rd_en), 128'd0);
    check("midrst y_out",       128'(y_out),       128'd0);
    check("midrst cycles_last", 128'(cycles_last), 128'd0);
    n_done = 0;
    n_rd   = 0;
    for (int t = 0; t < 12; t++) begin
      if (done) n_done++;
      if (bus.w_rd_en) n_rd++;
      @(posedge clk); #1;
    end
    check("midrst no_done", 128'(n_done), 128'd0);
    check("midrst no_rd",   128'(n_rd),   128'd0);

    run_vec(post, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
